// File: rtl/cmp3_seq_ctrl.sv
// rtl/cmp3_seq_ctrl.sv - valid/ready sequencer around a 3-bit comparator with saturating event counters
// Optional build macro CMP3_ONEHOT_CHK_EN enables the sticky gt/eq/lt one-hot check (err_onehot).
module cmp3_seq_ctrl #(
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_a,
  input  logic [2:0]       in_b,
  output logic [2:0]       cmp_in1,
  output logic [2:0]       cmp_in2,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res_gt,
  output logic             res_eq,
  output logic             res_lt,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic             err_onehot
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       capture;
  logic       cnt_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (out_valid && out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered images of the next state, so in_ready stays
  // low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == RESP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_in1    <= 3'd0;
      cmp_in2    <= 3'd0;
      settle_cnt <= 4'd0;
    end else if (accept) begin
      cmp_in1    <= in_a;
      cmp_in2    <= in_b;
      settle_cnt <= SETTLE_LOAD;
    end else if (state == SETTLE && settle_cnt != 4'd0) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_gt <= 1'b0;
      res_eq <= 1'b0;
      res_lt <= 1'b0;
    end else if (capture) begin
      res_gt <= cmp_gt;
      res_eq <= cmp_eq;
      res_lt <= cmp_lt;
    end
  end

`ifdef CMP3_ONEHOT_CHK_EN
  logic sample_bad;

  assign sample_bad = !({cmp_gt, cmp_eq, cmp_lt} inside {3'b100, 3'b010, 3'b001});
  assign cnt_en     = capture && !sample_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_onehot <= 1'b0;
    end else if (clr_cnt) begin
      err_onehot <= 1'b0;
    end else if (capture && sample_bad) begin
      err_onehot <= 1'b1;
    end
  end
`else
  assign cnt_en     = capture;
  assign err_onehot = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
    return (hit && c != CNT_MAX) ? c + CNT_ONE : c;
  endfunction

  // Clear beats a coincident capture; the result itself is still delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_cnt <= '0;
      eq_cnt <= '0;
      lt_cnt <= '0;
    end else if (clr_cnt) begin
      gt_cnt <= '0;
      eq_cnt <= '0;
      lt_cnt <= '0;
    end else if (cnt_en) begin
      gt_cnt <= sat_inc(gt_cnt, cmp_gt);
      eq_cnt <= sat_inc(eq_cnt, cmp_eq);
      lt_cnt <= sat_inc(lt_cnt, cmp_lt);
    end
  end

endmodule
